dt_img_mem: RTL and testbench

- Memory-side responder for the distance-transform (DT) engine.
- Owns the binary-image ROM (1024 x 16 bit) and the result RAM (16384 x 8 bit). Services the engine's sti_* reads and res_* reads/writes.
- Loads the image from a host stream before the engine runs.
- Expands the image into the result RAM, releases the engine, then streams the finished 128x128 result back to the host.

---
 rtl/dt_img_mem_if.sv | 36 +++
 rtl/dt_img_mem.sv | 152 +++++++++++++++
 tb/tb_dt_img_mem.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/dt_img_mem_if.sv
// Bundles the host load/dump streams and the DT engine memory strobes.
// Pure wiring, no latency of its own.
// Backpressure is carried by ld_ready toward the host and dump_ready from the host.
interface dt_img_mem_if;
  logic        ld_valid;
  logic [15:0] ld_data;
  logic        ld_ready;
  logic        dt_go;
  logic        sti_rd;
  logic [9:0]  sti_addr;
  logic [15:0] sti_di;
  logic        res_rd;
  logic        res_wr;
  logic [13:0] res_addr;
  logic [7:0]  res_do;
  logic [7:0]  res_di;
  logic        done;
  logic        dump_valid;
  logic [7:0]  dump_data;
  logic        dump_last;
  logic        dump_ready;

  // Host plus engine side: drives strobes, loads, done and dump_ready
  modport master (
    output ld_valid, ld_data, sti_rd, sti_addr, res_rd, res_wr, res_addr, res_do,
           done, dump_ready,
    input  ld_ready, dt_go, sti_di, res_di, dump_valid, dump_data, dump_last
  );

  // Memory side: owns the ROM and RAM and answers the strobes
  modport slave (
    input  ld_valid, ld_data, sti_rd, sti_addr, res_rd, res_wr, res_addr, res_do,
           done, dump_ready,
    output ld_ready, dt_go, sti_di, res_di, dump_valid, dump_data, dump_last
  );
endinterface

// File: rtl/dt_img_mem.sv
// Image ROM and result RAM behind the DT engine: load, expand, serve, dump.
// Reads return one cycle after the strobe; expansion takes 16385 cycles; dump is 2 cycles to first byte.
// ld_ready gates the load stream; the dump pipeline stalls as a unit while dump_ready is low.
module dt_img_mem #(
  parameter int IMG_W     = 128,
  parameter int STI_WORDS = 1024,
  parameter int RES_DEPTH = 16384
) (
  input logic         clk,
  input logic         reset,
  dt_img_mem_if.slave bus
);

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    INIT  = 2'd1,
    SERVE = 2'd2,
    DUMP  = 2'd3
  } state_t;

  localparam logic [9:0]  LD_LAST  = 10'(STI_WORDS - 1);
  localparam logic [13:0] PIX_LAST = 14'(IMG_W * IMG_W - 1);

  state_t      state;
  logic [15:0] rom [STI_WORDS];
  logic [7:0]  ram [RES_DEPTH];

  logic [9:0]  ld_cnt;
  logic [13:0] init_cnt;     // pixel address being written in INIT
  logic        init_fill;    // ROM pipeline holds the word for init_cnt
  logic [15:0] init_word;
  logic [13:0] dump_cnt;     // next RAM address to fetch for the dump
  logic        dump_end;     // every address has been fetched
  logic        pipe_vld;
  logic        pipe_last;
  logic [7:0]  pipe_dat;

  logic        ld_acc;
  logic [13:0] init_nxt;
  logic [9:0]  init_raddr;
  logic        init_wr;
  logic        dump_adv;
  logic        dump_issue;

  assign ld_acc     = (state == LOAD) && bus.ld_valid && bus.ld_ready;
  assign init_nxt   = init_cnt + 14'd1;
  // Prefetch the word for the pixel that is written on the next edge
  assign init_raddr = init_fill ? init_nxt[13:4] : init_cnt[13:4];
  assign init_wr    = (state == INIT) && init_fill;
  // Fetch and output stages advance together whenever the output slot frees up
  assign dump_adv   = (state == DUMP) && (!bus.dump_valid || bus.dump_ready);
  assign dump_issue = dump_adv && !dump_end;

  // Image ROM: host write port and the expansion read pipeline
  always_ff @(posedge clk) begin
    if (ld_acc) rom[ld_cnt] <= bus.ld_data;
    init_word <= rom[init_raddr];
  end

  // Result RAM: expansion and engine writes, dump fetch
  always_ff @(posedge clk) begin
    if (init_wr)
      ram[init_cnt] <= {7'd0, init_word[4'd15 - init_cnt[3:0]]};
    else if ((state == SERVE) && bus.res_wr)
      ram[bus.res_addr] <= bus.res_do;
    if (dump_issue) pipe_dat <= ram[dump_cnt];
  end

  // Phase sequencing, engine read ports and dump output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= LOAD;
      bus.ld_ready   <= 1'b0;
      bus.dt_go      <= 1'b0;
      bus.sti_di     <= '0;
      bus.res_di     <= '0;
      bus.dump_valid <= 1'b0;
      bus.dump_data  <= '0;
      bus.dump_last  <= 1'b0;
      ld_cnt         <= '0;
      init_cnt       <= '0;
      init_fill      <= 1'b0;
      dump_cnt       <= '0;
      dump_end       <= 1'b0;
      pipe_vld       <= 1'b0;
      pipe_last      <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          if (ld_acc && (ld_cnt == LD_LAST)) begin
            bus.ld_ready <= 1'b0;
            ld_cnt       <= '0;
            init_cnt     <= '0;
            init_fill    <= 1'b0;
            state        <= INIT;
          end else begin
            bus.ld_ready <= 1'b1;
            if (ld_acc) ld_cnt <= ld_cnt + 10'd1;
          end
        end
        INIT: begin
          if (!init_fill) begin
            init_fill <= 1'b1;
          end else if (init_cnt == PIX_LAST) begin
            init_fill <= 1'b0;
            init_cnt  <= '0;
            bus.dt_go <= 1'b1;
            state     <= SERVE;
          end else begin
            init_cnt <= init_nxt;
          end
        end
        SERVE: begin
          if (bus.sti_rd) bus.sti_di <= rom[bus.sti_addr];
          if (bus.res_rd && !bus.res_wr) bus.res_di <= ram[bus.res_addr];
          if (bus.done) begin
            bus.dt_go <= 1'b0;
            dump_cnt  <= '0;
            dump_end  <= 1'b0;
            pipe_vld  <= 1'b0;
            pipe_last <= 1'b0;
            state     <= DUMP;
          end
        end
        DUMP: begin
          if (dump_adv) begin
            bus.dump_valid <= pipe_vld;
            bus.dump_last  <= pipe_last;
            if (pipe_vld) bus.dump_data <= pipe_dat;
            pipe_vld <= !dump_end;
            if (!dump_end) begin
              pipe_last <= (dump_cnt == PIX_LAST);
              if (dump_cnt == PIX_LAST) dump_end <= 1'b1;
              else                      dump_cnt <= dump_cnt + 14'd1;
            end
          end
          if (bus.dump_valid && bus.dump_ready && bus.dump_last) begin
            bus.dump_valid <= 1'b0;
            bus.dump_last  <= 1'b0;
            pipe_vld       <= 1'b0;
            pipe_last      <= 1'b0;
            dump_cnt       <= '0;
            dump_end       <= 1'b0;
            state          <= LOAD;
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_dt_img_mem.sv
// Directed bench for dt_img_mem: load, expansion timing, engine port tables, dump, reset abort.
// Expected data comes from hand-written tables and a byte model of the result RAM.
// Dump runs once at full rate and once with random dump_ready stalls.
module tb_dt_img_mem;

  typedef struct {
    string       name;
    logic        sti_rd;
    logic [9:0]  sti_addr;
    logic        res_rd;
    logic        res_wr;
    logic [13:0] res_addr;
    logic [7:0]  res_do;
    logic [15:0] exp_sti;
    logic [7:0]  exp_res;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dt_img_mem_if b();
  dt_img_mem dut (.clk(clk), .reset(reset), .bus(b));

  int          nvec = 0;
  int          nerr = 0;
  logic [15:0] img   [1024];
  logic [7:0]  model [16384];
  vec_t        t1 [19];
  vec_t        t2 [7];

  function automatic vec_t mk(input string n, input logic s_rd, input logic [9:0] s_a,
                              input logic r_rd, input logic r_wr, input logic [13:0] r_a,
                              input logic [7:0] r_do, input logic [15:0] e_s,
                              input logic [7:0] e_r);
    vec_t v;
    v.name = n; v.sti_rd = s_rd; v.sti_addr = s_a; v.res_rd = r_rd; v.res_wr = r_wr;
    v.res_addr = r_a; v.res_do = r_do; v.exp_sti = e_s; v.exp_res = e_r;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    b.ld_valid = 1'b0; b.ld_data = '0; b.sti_rd = 1'b0; b.sti_addr = '0;
    b.res_rd = 1'b0; b.res_wr = 1'b0; b.res_addr = '0; b.res_do = '0;
    b.done = 1'b0; b.dump_ready = 1'b0;
  endtask

  task automatic rst_checks(input string tag);
    check({tag, "_ctl"}, {b.ld_ready, b.dt_go, b.dump_valid, b.dump_last}, 0);
    check({tag, "_rd"}, {b.sti_di, b.res_di}, 0);
    check({tag, "_dump_data"}, b.dump_data, 0);
  endtask

  task automatic build_model();
    for (int a = 0; a < 16384; a++) begin
      logic [13:0] ad;
      ad = a[13:0];
      model[a] = {7'd0, img[ad[13:4]][4'd15 - ad[3:0]]};
    end
  endtask

  task automatic load_image(input bit gapped);
    int acc = 0;
    int cyc = 0;
    while (acc < 1024 && cyc < 4000) begin
      b.ld_valid = gapped ? (cyc % 3 != 2) : 1'b1;
      b.ld_data  = img[acc];
      if (b.ld_valid && b.ld_ready) acc++;
      tick();
      cyc++;
    end
    check("load_accepts", acc, 1024);
    check("ld_ready_drop", b.ld_ready, 0);
  endtask

  // Counts cycles in INIT; keeps junk on the load port early on, which must be ignored
  task automatic wait_init();
    int n = 0;
    while (!b.dt_go && n < 17000) begin
      b.ld_valid = (n < 3);
      b.ld_data  = 16'hFFFF;
      tick();
      n++;
    end
    b.ld_valid = 1'b0;
    check("init_cycles", n, 16385);
  endtask

  task automatic apply_vec(input vec_t v);
    b.sti_rd = v.sti_rd; b.sti_addr = v.sti_addr; b.res_rd = v.res_rd;
    b.res_wr = v.res_wr; b.res_addr = v.res_addr; b.res_do = v.res_do;
    tick();
    b.sti_rd = 1'b0; b.res_rd = 1'b0; b.res_wr = 1'b0;
    if (v.res_wr) model[v.res_addr] = v.res_do;
    check({v.name, "_sti"}, b.sti_di, v.exp_sti);
    check({v.name, "_res"}, b.res_di, v.exp_res);
  endtask

  task automatic dump_check(input bit bp);
    int          idx = 0;
    int          cyc = 0;
    int          k = 0;
    bit          stalled = 0;
    logic [8:0]  held = '0;
    while (idx < 16384 && cyc < 60000) begin
      logic rdy;
      rdy = (bp && idx < 4096) ? 1'($urandom % 2) : 1'b1;
      b.dump_ready = rdy;
      if (stalled) check("dump_hold", {b.dump_valid, b.dump_last, b.dump_data}, {1'b1, held});
      if (!bp && idx > 0) check("dump_nobubble", b.dump_valid, 1);
      if (b.dump_valid && rdy) begin
        check("dump_byte", {b.dump_last, b.dump_data}, {idx == 16383, model[idx]});
        idx++;
      end
      stalled = b.dump_valid && !rdy;
      held    = {b.dump_last, b.dump_data};
      tick();
      cyc++;
    end
    b.dump_ready = 1'b0;
    check("dump_count", idx, 16384);
    check("dump_valid_after_last", b.dump_valid, 0);
    while (!b.ld_ready && k < 4) begin
      tick();
      k++;
    end
    check("back_to_load", b.ld_ready, 1);
  endtask

  initial begin
    // Engine port vectors over the 8001 image with word 513 = A5C3
    t1[0]  = mk("rd0",      0, 10'd0,    1, 0, 14'd0,     8'd0,   16'h0000, 8'd1);
    t1[1]  = mk("rd15",     0, 10'd0,    1, 0, 14'd15,    8'd0,   16'h0000, 8'd1);
    t1[2]  = mk("rd16",     0, 10'd0,    1, 0, 14'd16,    8'd0,   16'h0000, 8'd1);
    t1[3]  = mk("rd14",     0, 10'd0,    1, 0, 14'd14,    8'd0,   16'h0000, 8'd0);
    t1[4]  = mk("rd8208",   0, 10'd0,    1, 0, 14'd8208,  8'd0,   16'h0000, 8'd1);
    t1[5]  = mk("rd8209",   0, 10'd0,    1, 0, 14'd8209,  8'd0,   16'h0000, 8'd0);
    t1[6]  = mk("sti513",   1, 10'd513,  0, 0, 14'd0,     8'd0,   16'hA5C3, 8'd0);
    for (int i = 7; i < 12; i++)
      t1[i] = mk("sti_hold", 0, 10'd0,  0, 0, 14'd0,     8'd0,   16'hA5C3, 8'd0);
    t1[12] = mk("sti1023",  1, 10'd1023, 0, 0, 14'd0,     8'd0,   16'h8001, 8'd0);
    t1[13] = mk("wr102",    0, 10'd0,    0, 1, 14'h0102,  8'd37,  16'h8001, 8'd0);
    t1[14] = mk("raw102",   0, 10'd0,    1, 0, 14'h0102,  8'd0,   16'h8001, 8'd37);
    t1[15] = mk("rdwr103",  0, 10'd0,    1, 1, 14'h0103,  8'd99,  16'h8001, 8'd37);
    t1[16] = mk("rd103",    0, 10'd0,    1, 0, 14'h0103,  8'd0,   16'h8001, 8'd99);
    t1[17] = mk("wr3fff",   0, 10'd0,    0, 1, 14'h3FFF,  8'hAB,  16'h8001, 8'd99);
    t1[18] = mk("rd3fff",   0, 10'd0,    1, 0, 14'h3FFF,  8'd0,   16'h8001, 8'hAB);
    // Engine port vectors over the reloaded all-zero image
    t2[0]  = mk("z_wr5",    0, 10'd0,    0, 1, 14'd5,     8'h11,  16'h0000, 8'd0);
    t2[1]  = mk("z_wr5000", 0, 10'd0,    0, 1, 14'd5000,  8'h22,  16'h0000, 8'd0);
    t2[2]  = mk("z_rd5",    0, 10'd0,    1, 0, 14'd5,     8'd0,   16'h0000, 8'h11);
    t2[3]  = mk("z_rd6",    0, 10'd0,    1, 0, 14'd6,     8'd0,   16'h0000, 8'd0);
    t2[4]  = mk("z_sti513", 1, 10'd513,  0, 0, 14'd0,     8'd0,   16'h0000, 8'd0);
    t2[5]  = mk("z_rd5000", 0, 10'd0,    1, 0, 14'd5000,  8'd0,   16'h0000, 8'h22);
    t2[6]  = mk("z_wr3fff", 0, 10'd0,    0, 1, 14'h3FFF,  8'h7E,  16'h0000, 8'h22);

    idle_inputs();
    reset = 1'b1;
    #2 reset = 1'b0;
    tick();
    tick();
    rst_checks("reset");
    reset = 1'b1;
    tick();
    check("ld_ready_after_reset", b.ld_ready, 1);

    // Flow 1: gapped load, expansion, engine traffic, full-rate dump
    for (int i = 0; i < 1024; i++) img[i] = 16'h8001;
    img[513] = 16'hA5C3;
    build_model();
    load_image(1'b1);
    wait_init();
    check("dt_go_serve", b.dt_go, 1);
    foreach (t1[i]) apply_vec(t1[i]);

    b.done = 1'b1;
    tick();
    b.done = 1'b0;
    check("dt_go_drop", b.dt_go, 0);
    b.res_wr = 1'b1; b.res_addr = 14'h0102; b.res_do = 8'd55;
    b.sti_rd = 1'b1; b.sti_addr = 10'd513;
    tick();
    b.res_wr = 1'b0; b.sti_rd = 1'b0;
    check("sti_ignored_in_dump", b.sti_di, 16'h8001);
    tick();
    check("dump_valid_rise", b.dump_valid, 1);
    dump_check(1'b0);

    // Flow 2: abort an all-ones expansion midway, reload zeros, stalled dump
    for (int i = 0; i < 1024; i++) img[i] = 16'hFFFF;
    load_image(1'b0);
    repeat (5001) tick();
    reset = 1'b0;
    #1;
    rst_checks("midreset");
    tick();
    tick();
    reset = 1'b1;
    tick();
    check("ld_ready_after_midreset", b.ld_ready, 1);

    for (int i = 0; i < 1024; i++) img[i] = 16'h0000;
    build_model();
    load_image(1'b0);
    wait_init();
    foreach (t2[i]) apply_vec(t2[i]);
    b.done = 1'b1;
    tick();
    b.done = 1'b0;
    check("z_dt_go_drop", b.dt_go, 0);
    dump_check(1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
